// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with arbitrary depth and an optional first-word-fall-through
// read mode. It provides programmable almost-full/almost-empty thresholds, an
// occupancy count, sticky overflow/underflow flags and a synchronous flush.
// Every status flag is a register. Each flag is loaded from the count value the
// FIFO will hold after the edge, so it always matches the registered count.
module sync_fifo_thresh #(
  parameter int  DATA_WIDTH = 8,
  parameter int  DEPTH      = 16,
  parameter int  AFULL_TH   = DEPTH - 2,
  parameter int  AEMPTY_TH  = 2,
  parameter bit  FWFT       = 1'b0,
  localparam int PTR_WIDTH  = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ZERO = PTR_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AF   = CNT_WIDTH'(AFULL_TH);
  localparam logic [CNT_WIDTH-1:0] CNT_AE   = CNT_WIDTH'(AEMPTY_TH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]  wptr_r, rptr_r, wptr_nxt_s, rptr_nxt_s;
  logic [CNT_WIDTH-1:0]  count_r, cnt_nxt_s;
  logic                  full_r, empty_r, afull_r, aempty_r;
  logic                  ovf_r, unf_r;
  logic [DATA_WIDTH-1:0] dout_r;
  logic                  wr_acc_s, rd_acc_s;

  // Access acceptance uses only the pre-edge flags. Flush suppresses both accesses.
  always_comb begin
    wr_acc_s = 1'b0;
    rd_acc_s = 1'b0;
    if (flush) begin
      wr_acc_s = 1'b0;
      rd_acc_s = 1'b0;
    end else begin
      wr_acc_s = w_en && !full_r;
      rd_acc_s = r_en && !empty_r;
    end
  end

  // Next pointer and count values. Pointers wrap at DEPTH-1 by explicit compare.
  always_comb begin
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    cnt_nxt_s  = count_r;
    if (flush) begin
      wptr_nxt_s = PTR_ZERO;
      rptr_nxt_s = PTR_ZERO;
      cnt_nxt_s  = CNT_ZERO;
    end else begin
      if (wr_acc_s) begin
        if (wptr_r == PTR_LAST) begin
          wptr_nxt_s = PTR_ZERO;
        end else begin
          wptr_nxt_s = wptr_r + PTR_ONE;
        end
      end else begin
        wptr_nxt_s = wptr_r;
      end
      if (rd_acc_s) begin
        if (rptr_r == PTR_LAST) begin
          rptr_nxt_s = PTR_ZERO;
        end else begin
          rptr_nxt_s = rptr_r + PTR_ONE;
        end
      end else begin
        rptr_nxt_s = rptr_r;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   cnt_nxt_s = count_r + CNT_ONE;
        2'b01:   cnt_nxt_s = count_r - CNT_ONE;
        default: cnt_nxt_s = count_r;
      endcase
    end
  end

  // Control state, registered flags, sticky errors and the read-data holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r   <= PTR_ZERO;
      rptr_r   <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      afull_r  <= 1'b0;
      aempty_r <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      dout_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      wptr_r   <= wptr_nxt_s;
      rptr_r   <= rptr_nxt_s;
      count_r  <= cnt_nxt_s;
      full_r   <= (cnt_nxt_s == CNT_FULL);
      empty_r  <= (cnt_nxt_s == CNT_ZERO);
      afull_r  <= (cnt_nxt_s >= CNT_AF);
      aempty_r <= (cnt_nxt_s <= CNT_AE);
      if (flush) begin
        ovf_r <= 1'b0;
        unf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r | (w_en & full_r);
        unf_r <= unf_r | (r_en & empty_r);
      end
      // In FWFT mode, a flush captures the visible head word so data_out does not change.
      if (rd_acc_s) begin
        dout_r <= mem_r[rptr_r];
      end else if (flush && FWFT && !empty_r) begin
        dout_r <= mem_r[rptr_r];
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  // Storage array; it is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wptr_r] <= data_in;
    end
  end

  // FWFT shows the head word while data is present; otherwise the held register is shown.
  always_comb begin
    data_out = dout_r;
    if (FWFT && !empty_r) begin
      data_out = mem_r[rptr_r];
    end else begin
      data_out = dout_r;
    end
  end

  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench for sync_fifo_thresh. It uses two DEPTH=6 instances: one with
// a registered read and one in first-word-fall-through mode. Flag and count
// expectations come from a vector table. Read data is checked against a queue
// scoreboard.
module tb_sync_fifo_thresh;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       flush0, w_en0, r_en0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [7:0] din0, dout0;
  logic [2:0] cnt0;
  logic       flush1, w_en1, r_en1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [7:0] din1, dout1;
  logic [2:0] cnt1;

  sync_fifo_thresh #(.DATA_WIDTH(8), .DEPTH(6), .AFULL_TH(4), .AEMPTY_TH(2), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .flush(flush0), .w_en(w_en0), .data_in(din0), .r_en(r_en0),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_thresh #(.DATA_WIDTH(8), .DEPTH(6), .AFULL_TH(4), .AEMPTY_TH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush1), .w_en(w_en1), .data_in(din1), .r_en(r_en1),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last0, last1;

  // flg = {full, empty, almost_full, almost_empty, overflow, underflow}
  typedef struct {
    logic       w;
    logic       r;
    logic       f;
    logic [7:0] d;
    logic [2:0] cnt;
    logic [5:0] flg;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic w, input logic r, input logic f, input logic [7:0] d,
                              input logic [2:0] c, input logic [5:0] fl);
    vec_t v;
    v.w = w; v.r = r; v.f = f; v.d = d; v.cnt = c; v.flg = fl;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock of stimulus on the registered-read instance, followed by a data check.
  task automatic step0(input logic w, input logic r, input logic f, input logic [7:0] d);
    logic wa, ra;
    wa = w && !f && (q0.size() < 6);
    ra = r && !f && (q0.size() > 0);
    w_en0 = w; r_en0 = r; flush0 = f; din0 = d;
    @(posedge clk); #1;
    w_en0 = 1'b0; r_en0 = 1'b0; flush0 = 1'b0;
    if (f) q0.delete();
    else begin
      if (ra) last0 = q0.pop_front();
      if (wa) q0.push_back(d);
    end
    chk("dout_std", 32'(dout0), 32'(last0));
  endtask

  // One clock of stimulus on the FWFT instance. The head word must be visible without r_en.
  task automatic step1(input logic w, input logic r, input logic [7:0] d);
    logic wa, ra;
    logic [7:0] exp;
    wa = w && (q1.size() < 6);
    ra = r && (q1.size() > 0);
    w_en1 = w; r_en1 = r; din1 = d;
    @(posedge clk); #1;
    w_en1 = 1'b0; r_en1 = 1'b0;
    if (ra) last1 = q1.pop_front();
    if (wa) q1.push_back(d);
    exp = (q1.size() > 0) ? q1[0] : last1;
    chk("dout_fwft", 32'(dout1), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    flush0 = 1'b0; w_en0 = 1'b0; r_en0 = 1'b0; din0 = 8'h00;
    flush1 = 1'b0; w_en1 = 1'b0; r_en1 = 1'b0; din1 = 8'h00;
    last0 = 8'h00; last1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt_std", 32'(cnt0), 32'd0);
    chk("rst_flg_std", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'(6'b010100));
    chk("rst_dout_std", 32'(dout0), 32'd0);
    chk("rst_flg_fwft", 32'({full1, empty1, af1, ae1, ovf1, unf1}), 32'(6'b010100));
    chk("rst_dout_fwft", 32'(dout1), 32'd0);
    rst = 1'b0;

    // Fill to full, write at full, drain, boundary simultaneous accesses, flush cases.
    add(1'b1, 1'b0, 1'b0, 8'h01, 3'd1, 6'b000100);
    add(1'b1, 1'b0, 1'b0, 8'h02, 3'd2, 6'b000100);
    add(1'b1, 1'b0, 1'b0, 8'h03, 3'd3, 6'b000000);
    add(1'b1, 1'b0, 1'b0, 8'h04, 3'd4, 6'b001000);
    add(1'b1, 1'b0, 1'b0, 8'h05, 3'd5, 6'b001000);
    add(1'b1, 1'b0, 1'b0, 8'h06, 3'd6, 6'b101000);
    add(1'b1, 1'b1, 1'b0, 8'h07, 3'd5, 6'b001010);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 6'b001010);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 6'b000010);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 6'b000110);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 6'b000110);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010110);
    add(1'b1, 1'b1, 1'b0, 8'h11, 3'd1, 6'b000111);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010111);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010111);
    add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 6'b010100);
    add(1'b1, 1'b0, 1'b0, 8'h21, 3'd1, 6'b000100);
    add(1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 6'b000100);
    add(1'b1, 1'b0, 1'b0, 8'h23, 3'd3, 6'b000000);
    add(1'b1, 1'b0, 1'b0, 8'h24, 3'd4, 6'b001000);
    add(1'b1, 1'b0, 1'b0, 8'h25, 3'd5, 6'b001000);
    add(1'b1, 1'b0, 1'b0, 8'h26, 3'd6, 6'b101000);
    add(1'b1, 1'b0, 1'b0, 8'h27, 3'd6, 6'b101010);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd5, 6'b001010);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 6'b001010);
    add(1'b1, 1'b0, 1'b1, 8'h99, 3'd0, 6'b010100);
    add(1'b1, 1'b0, 1'b0, 8'h31, 3'd1, 6'b000100);
    add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 6'b010100);

    foreach (vq[i]) begin
      step0(vq[i].w, vq[i].r, vq[i].f, vq[i].d);
      chk($sformatf("vec%0d_cnt", i), 32'(cnt0), 32'(vq[i].cnt));
      chk($sformatf("vec%0d_flg", i), 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'(vq[i].flg));
    end

    // Pointer wrap: keep three entries queued while reading and writing every cycle.
    for (int i = 0; i < 3; i++) step0(1'b1, 1'b0, 1'b0, 8'($urandom_range(1, 255)));
    for (int i = 0; i < 20; i++) begin
      step0(1'b1, 1'b1, 1'b0, 8'($urandom_range(1, 255)));
      chk("wrap_cnt", 32'(cnt0), 32'd3);
    end
    for (int i = 0; i < 3; i++) step0(1'b0, 1'b1, 1'b0, 8'h00);
    chk("wrap_drain_cnt", 32'(cnt0), 32'd0);
    chk("wrap_drain_empty", 32'(empty0), 32'd1);

    // FWFT: a word appears one cycle after the write, and a pop empties the FIFO.
    step1(1'b1, 1'b0, 8'hA5);
    chk("fwft_not_empty", 32'(empty1), 32'd0);
    step1(1'b0, 1'b0, 8'h00);
    step1(1'b0, 1'b1, 8'h00);
    chk("fwft_empty_after_pop", 32'(empty1), 32'd1);
    step1(1'b1, 1'b0, 8'hB1);
    step1(1'b1, 1'b0, 8'hB2);
    step1(1'b0, 1'b1, 8'h00);
    chk("fwft_cnt", 32'(cnt1), 32'd1);
    step1(1'b0, 1'b1, 8'h00);
    chk("fwft_empty_end", 32'(empty1), 32'd1);

    // Assert reset asynchronously in the middle of a write burst.
    step0(1'b1, 1'b0, 1'b0, 8'h51);
    step0(1'b1, 1'b0, 1'b0, 8'h52);
    w_en0 = 1'b1; din0 = 8'h53;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(cnt0), 32'd0);
    chk("async_rst_flg", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'(6'b010100));
    chk("async_rst_dout", 32'(dout0), 32'd0);
    chk("async_rst_dout_fwft", 32'(dout1), 32'd0);
    w_en0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete(); last0 = 8'h00;
    q1.delete(); last1 = 8'h00;
    step0(1'b1, 1'b0, 1'b0, 8'h61);
    chk("post_rst_cnt", 32'(cnt0), 32'd1);
    step0(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_rst_flg", 32'({full0, empty0, af0, ae0, ovf0, unf0}), 32'(6'b010100));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
